uart_rx_core: RTL and testbench
===============================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter DATA_WIDTH, default 8, meaning data bits per frame (only 8 supported).
REQ-002 Port clk  input  1  oversampling clock (Prescale x baud).
REQ-003 Port RST  input  1  asynchronous active-low reset, already synchronized upstream.
REQ-004 Port RX_IN  input  1  serial line; idle high; frame = start(0), 8 data LSB-first, optional parity, stop(1).
REQ-005 Port Prescale  input  6  oversampling ratio: 8, 16 or 32; any other value SHALL be treated as 8.
REQ-006 Port PAR_EN  input  1  1 = frame carries a parity bit.
REQ-007 Port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 Port P_DATA  output  8  received byte.
REQ-009 Port Data_Valid  output  1  one-cycle pulse; P_DATA holds a good byte.
REQ-010 Port Par_err  output  1  parity mismatch on the last frame.
REQ-011 Port Stp_err  output  1  stop bit sampled low on the last frame.

Function
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-013 Bit timing: edge counter edge_cnt counts 0..Prescale-1 per bit; bit counter counts data bits 0..7.
REQ-014 IDLE: RX_IN==0 on a clk edge -> START; the detection cycle is edge_cnt=0 of the start bit (cycle t).
REQ-015 Each bit value SHALL be the 2-of-3 majority of RX_IN sampled at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1.
REQ-016 START: at edge_cnt=Prescale-1, sampled 0 -> DATA; sampled 1 (glitch) -> IDLE, no outputs change.
REQ-017 DATA: sampled bits shift into an internal register LSB-first; after bit 7 at edge_cnt=Prescale-1 -> PARITY if PAR_EN else STOP.
REQ-018 PARITY: received bit compared with XOR of the 8 data bits (inverted when PAR_TYP=1); result latched; -> STOP at edge_cnt=Prescale-1.
REQ-019 STOP: at edge_cnt=Prescale-1 -> IDLE; Par_err and Stp_err update on the same edge; P_DATA loads and Data_Valid pulses one cycle only when both errors are 0.
REQ-020 Data_Valid SHALL rise at cycle t+11*Prescale with parity, t+10*Prescale without; width exactly 1 clk.
REQ-021 On an errored frame P_DATA SHALL keep its previous value and Data_Valid SHALL stay 0.
REQ-022 Par_err/Stp_err SHALL hold until the next frame's STOP evaluation or reset; Par_err forced 0 when PAR_EN=0.
REQ-023 Back-to-back frames: RX_IN low in the first IDLE cycle after STOP SHALL be detected as a new start with no lost cycle.
REQ-024 PAR_EN, PAR_TYP and Prescale SHALL be sampled only in IDLE; changes mid-frame do not affect the current frame.
REQ-025 RX_IN held low continuously: frame completes with Stp_err=1, then each later IDLE cycle starts a new frame.

Reset
REQ-026 RST=0 SHALL asynchronously force state IDLE, counters 0, P_DATA=0x00, Data_Valid=0, Par_err=0, Stp_err=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no Data_Valid; reception resumes at the next falling edge after RST=1.

Verification
REQ-028 Prescale=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity 0, stop 1 -> Data_Valid at t+88, P_DATA=0xA5, both errors 0.
REQ-029 Prescale=16, PAR_EN=0, frame 0x3C -> Data_Valid at t+160, P_DATA=0x3C; repeat with Prescale=32, 0xFF -> pulse at t+320.
REQ-030 Prescale=8, PAR_TYP=1, frame 0x01 with parity 1 (wrong) -> Par_err=1, no Data_Valid, P_DATA unchanged.
REQ-031 Stop bit driven 0 on frame 0x55 -> Stp_err=1, no Data_Valid; next good frame 0x12 clears Stp_err and pulses Data_Valid.
REQ-032 3-cycle low glitch on idle line (Prescale=8) -> returns to IDLE, no output change; single-cycle flip at a middle sample -> majority keeps correct byte.
REQ-033 Two back-to-back frames 0x11, 0x22 (Prescale=8, no parity), then RST=0 during third frame's DATA -> two pulses 80 clk apart, all outputs 0 after reset.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver for 8N1 / 8E1 / 8O1 frames.
//
// Each bit is Prescale clk cycles long. The bit value is the 2-of-3 majority of
// the line sampled around the middle of the bit. The received byte is
// presented with a one-cycle Data_Valid pulse, but only when both the parity
// check and the stop-bit check pass.
//
// Ports
//   clk        oversampling clock (Prescale x baud)
//   RST        asynchronous active-low reset, already synchronized upstream
//   RX_IN      serial line, idle high
//   Prescale   oversampling ratio 8/16/32; any other value behaves as 8
//   PAR_EN     1 = frame carries a parity bit
//   PAR_TYP    0 = even parity, 1 = odd parity
//   P_DATA     last good byte received
//   Data_Valid one-cycle pulse when P_DATA has just loaded a good byte
//   Par_err    parity mismatch on the last frame
//   Stp_err    stop bit sampled low on the last frame
//
// state  | meaning
// IDLE   | line idle; config captured every cycle; a low line starts a frame
// START  | start bit; a high majority sample means it was a glitch
// DATA   | DATA_WIDTH data bits, LSB first, shifted into shift_q
// PARITY | parity bit compared against the data; result held in par_bad
// STOP   | stop bit; error flags, P_DATA and Data_Valid update at its end

module uart_rx_core #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [5:0]            Prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  Data_Valid,
   output logic                  Par_err,
   output logic                  Stp_err
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                state, state_nxt;
   logic [5:0]            edge_cnt;
   logic [2:0]            bit_cnt;
   logic [5:0]            prsc_q;
   logic [5:0]            prsc_sel;
   logic [5:0]            half;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic [2:0]            samp;
   logic [DATA_WIDTH-1:0] shift_q;
   logic                  par_bad;
   logic                  line_armed;
   logic                  start_det;
   logic                  bit_end;
   logic                  mid_samp;
   logic                  bit_val;
   logic                  last_bit;
   logic                  frame_end;
   logic                  frame_good;

   assign prsc_sel   = (Prescale == 6'd16 || Prescale == 6'd32) ? Prescale : 6'd8;
   assign half       = {1'b0, prsc_q[5:1]};
   assign bit_end    = (edge_cnt == prsc_q - 6'd1);
   assign mid_samp   = (edge_cnt == half - 6'd1) || (edge_cnt == half) ||
                       (edge_cnt == half + 6'd1);
   assign bit_val    = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
   assign last_bit   = (bit_cnt == 3'(DATA_WIDTH - 1));
   // After reset the line must be seen high once, so a reset released in the
   // middle of someone else's frame does not lock onto a data bit.
   assign start_det  = (state == IDLE) && !RX_IN && line_armed;
   assign frame_end  = (state == STOP) && bit_end;
   assign frame_good = bit_val && !(par_en_q && par_bad);

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_det) state_nxt = START;
         START:   if (bit_end) state_nxt = bit_val ? IDLE : DATA;
         DATA:    if (bit_end && last_bit) state_nxt = par_en_q ? PARITY : STOP;
         PARITY:  if (bit_end) state_nxt = STOP;
         STOP:    if (bit_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The detection cycle is edge 0 of the start bit, so START begins at 1.
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         edge_cnt <= 6'd0;
         bit_cnt  <= 3'd0;
         samp     <= 3'd0;
      end else if (state == IDLE) begin
         edge_cnt <= start_det ? 6'd1 : 6'd0;
         bit_cnt  <= 3'd0;
      end else begin
         edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
         if (state == DATA && bit_end) bit_cnt <= bit_cnt + 3'd1;
         if (mid_samp) samp <= {samp[1:0], RX_IN};
      end
   end

   // Frame format is frozen for the whole frame once the start is detected.
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         prsc_q    <= 6'd8;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
      end else if (state == IDLE) begin
         prsc_q    <= prsc_sel;
         par_en_q  <= PAR_EN;
         par_typ_q <= PAR_TYP;
      end
   end

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         shift_q    <= '0;
         par_bad    <= 1'b0;
         line_armed <= 1'b0;
      end else begin
         if (state == DATA && bit_end) shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
         if (state == PARITY && bit_end) par_bad <= bit_val ^ (^shift_q) ^ par_typ_q;
         if (RX_IN || frame_end) line_armed <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         P_DATA     <= '0;
         Data_Valid <= 1'b0;
         Par_err    <= 1'b0;
         Stp_err    <= 1'b0;
      end else begin
         Data_Valid <= 1'b0;
         if (frame_end) begin
            Par_err <= par_en_q & par_bad;
            Stp_err <= ~bit_val;
            if (frame_good) begin
               P_DATA     <= shift_q;
               Data_Valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core. Each frame sent pushes its expected
// outcome (pulse cycle, P_DATA, error flags) onto exp_q; a monitor records
// every Data_Valid pulse into dv_q, and each test pops and compares both.

module tb_uart_rx_core;

   logic       clk = 1'b0;
   logic       RST;
   logic       RX_IN;
   logic [5:0] Prescale;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       Par_err;
   logic       Stp_err;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int         cyc;
      logic [7:0] data;
   } dv_t;

   typedef struct {
      int         cyc;
      logic       valid;
      logic [7:0] pdata;
      logic       perr;
      logic       serr;
   } exp_t;

   dv_t  dv_q[$];
   exp_t exp_q[$];

   logic [7:0] model_pdata;
   logic       model_perr;
   logic       model_serr;

   uart_rx_core #(.DATA_WIDTH(8)) dut (
      .clk        (clk),
      .RST        (RST),
      .RX_IN      (RX_IN),
      .Prescale   (Prescale),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .Par_err    (Par_err),
      .Stp_err    (Stp_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      dv_t d;
      if (Data_Valid === 1'b1) begin
         d.cyc  = cyc;
         d.data = P_DATA;
         dv_q.push_back(d);
      end
   end

   // Drives one frame starting at a falling clk edge. t is the cycle in which
   // the start bit first appears on the line. The frame format inputs are
   // scrambled while the frame is in flight and restored for the stop bit.
   task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                             input logic pbit, input logic sbit, input logic [5:0] p,
                             input int flip_i, input logic b2b, output int t);
      logic [10:0] bits;
      int          nb;
      int          peff;
      logic        perr;
      logic        serr;
      exp_t        e;
      peff = (p == 6'd16 || p == 6'd32) ? int'(p) : 8;
      nb   = pen ? 11 : 10;
      bits = pen ? {sbit, pbit, d, 1'b0} : {1'b1, sbit, d, 1'b0};
      if (!b2b) begin
         @(negedge clk);
         Prescale = p;
         PAR_EN   = pen;
         PAR_TYP  = ptyp;
         RX_IN    = 1'b1;
         @(negedge clk);
      end
      t    = cyc;
      perr = pen && (pbit != ((^d) ^ ptyp));
      serr = !sbit;
      if (!perr && !serr) model_pdata = d;
      model_perr = perr;
      model_serr = serr;
      e.cyc   = t + nb * peff;
      e.valid = !perr && !serr;
      e.pdata = model_pdata;
      e.perr  = perr;
      e.serr  = serr;
      exp_q.push_back(e);
      for (int i = 0; i < nb; i++) begin
         if (i == 1) begin
            Prescale = (peff == 8) ? 6'd32 : 6'd8;
            PAR_EN   = ~pen;
            PAR_TYP  = ~ptyp;
         end
         if (i == nb - 1) begin
            Prescale = p;
            PAR_EN   = pen;
            PAR_TYP  = ptyp;
         end
         for (int k = 0; k < peff; k++) begin
            RX_IN = (i == flip_i && k == peff / 2) ? ~bits[i] : bits[i];
            @(negedge clk);
         end
      end
      RX_IN = 1'b1;
   endtask

   task automatic test_reset();
      #3 RST = 1'b0;
      #1;
      checks++;
      if (P_DATA !== 8'h00) begin
         errors++;
         $display("FAIL reset_p_data got %h exp 00", P_DATA);
      end
      checks++;
      if (Data_Valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_data_valid got %b exp 0", Data_Valid);
      end
      checks++;
      if (Par_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_par_err got %b exp 0", Par_err);
      end
      checks++;
      if (Stp_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_stp_err got %b exp 0", Stp_err);
      end
      repeat (3) @(negedge clk);
      RST = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // 0xA5 with correct even parity, then 0x01 odd parity with a wrong parity bit.
   task automatic test_parity();
      exp_t e;
      dv_t  d;
      int   t;
      for (int f = 0; f < 2; f++) begin
         if (f == 0) send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 6'd8, -1, 1'b0, t);
         else        send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 6'd8, -1, 1'b0, t);
         repeat (4) @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.valid) begin
               checks++;
               if (dv_q.size() == 0) begin
                  errors++;
                  $display("FAIL parity_dv_missing frame %0d got none exp cycle %0d", f, e.cyc);
               end else begin
                  d = dv_q.pop_front();
                  if (d.cyc !== e.cyc) begin
                     errors++;
                     $display("FAIL parity_dv_cycle frame %0d got %0d exp %0d", f, d.cyc, e.cyc);
                  end
                  checks++;
                  if (d.data !== e.pdata) begin
                     errors++;
                     $display("FAIL parity_dv_data frame %0d got %h exp %h", f, d.data, e.pdata);
                  end
               end
            end
         end
         checks++;
         if (dv_q.size() != 0) begin
            errors++;
            $display("FAIL parity_extra_dv frame %0d got %0d pulses exp 0", f, dv_q.size());
         end
         checks++;
         if (P_DATA !== e.pdata) begin
            errors++;
            $display("FAIL parity_p_data frame %0d got %h exp %h", f, P_DATA, e.pdata);
         end
         checks++;
         if (Par_err !== e.perr || Stp_err !== e.serr) begin
            errors++;
            $display("FAIL parity_flags frame %0d got par %b stp %b exp par %b stp %b",
                     f, Par_err, Stp_err, e.perr, e.serr);
         end
         dv_q.delete();
      end
   endtask

   // 0x3C at Prescale 16, then 0xFF at Prescale 32, no parity.
   task automatic test_no_parity();
      exp_t e;
      dv_t  d;
      int   t;
      for (int f = 0; f < 2; f++) begin
         if (f == 0) send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 6'd16, -1, 1'b0, t);
         else        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 6'd32, -1, 1'b0, t);
         repeat (4) @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.valid) begin
               checks++;
               if (dv_q.size() == 0) begin
                  errors++;
                  $display("FAIL nopar_dv_missing frame %0d got none exp cycle %0d", f, e.cyc);
               end else begin
                  d = dv_q.pop_front();
                  if (d.cyc !== e.cyc) begin
                     errors++;
                     $display("FAIL nopar_dv_cycle frame %0d got %0d exp %0d", f, d.cyc, e.cyc);
                  end
                  checks++;
                  if (d.data !== e.pdata) begin
                     errors++;
                     $display("FAIL nopar_dv_data frame %0d got %h exp %h", f, d.data, e.pdata);
                  end
               end
            end
         end
         checks++;
         if (dv_q.size() != 0) begin
            errors++;
            $display("FAIL nopar_extra_dv frame %0d got %0d pulses exp 0", f, dv_q.size());
         end
         checks++;
         if (Par_err !== e.perr || Stp_err !== e.serr) begin
            errors++;
            $display("FAIL nopar_flags frame %0d got par %b stp %b exp par %b stp %b",
                     f, Par_err, Stp_err, e.perr, e.serr);
         end
         dv_q.delete();
      end
   endtask

   // 0x55 with a low stop bit, then a good 0x12 that clears the error.
   task automatic test_stop_err();
      exp_t e;
      dv_t  d;
      int   t;
      for (int f = 0; f < 2; f++) begin
         if (f == 0) send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 6'd8, -1, 1'b0, t);
         else        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 6'd8, -1, 1'b0, t);
         repeat (4) @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.valid) begin
               checks++;
               if (dv_q.size() == 0) begin
                  errors++;
                  $display("FAIL stop_dv_missing frame %0d got none exp cycle %0d", f, e.cyc);
               end else begin
                  d = dv_q.pop_front();
                  if (d.cyc !== e.cyc || d.data !== e.pdata) begin
                     errors++;
                     $display("FAIL stop_dv frame %0d got cycle %0d data %h exp cycle %0d data %h",
                              f, d.cyc, d.data, e.cyc, e.pdata);
                  end
               end
            end
         end
         checks++;
         if (dv_q.size() != 0) begin
            errors++;
            $display("FAIL stop_extra_dv frame %0d got %0d pulses exp 0", f, dv_q.size());
         end
         checks++;
         if (P_DATA !== e.pdata) begin
            errors++;
            $display("FAIL stop_p_data frame %0d got %h exp %h", f, P_DATA, e.pdata);
         end
         checks++;
         if (Stp_err !== e.serr || Par_err !== e.perr) begin
            errors++;
            $display("FAIL stop_flags frame %0d got par %b stp %b exp par %b stp %b",
                     f, Par_err, Stp_err, e.perr, e.serr);
         end
         dv_q.delete();
      end
   endtask

   // 3-cycle low glitch on the idle line, then 0x96 with one data sample
   // flipped, sent with an unsupported Prescale (12) that must behave as 8.
   task automatic test_glitch_majority();
      exp_t e;
      dv_t  d;
      int   t;
      for (int f = 0; f < 2; f++) begin
         if (f == 0) begin
            @(negedge clk);
            Prescale = 6'd8;
            PAR_EN   = 1'b0;
            PAR_TYP  = 1'b0;
            RX_IN    = 1'b1;
            @(negedge clk);
            e.cyc   = 0;
            e.valid = 1'b0;
            e.pdata = model_pdata;
            e.perr  = model_perr;
            e.serr  = model_serr;
            exp_q.push_back(e);
            RX_IN = 1'b0;
            repeat (3) @(negedge clk);
            RX_IN = 1'b1;
            repeat (12) @(negedge clk);
         end else begin
            send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 6'd12, 4, 1'b0, t);
         end
         repeat (4) @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.valid) begin
               checks++;
               if (dv_q.size() == 0) begin
                  errors++;
                  $display("FAIL glitch_dv_missing case %0d got none exp cycle %0d", f, e.cyc);
               end else begin
                  d = dv_q.pop_front();
                  if (d.cyc !== e.cyc || d.data !== e.pdata) begin
                     errors++;
                     $display("FAIL glitch_dv case %0d got cycle %0d data %h exp cycle %0d data %h",
                              f, d.cyc, d.data, e.cyc, e.pdata);
                  end
               end
            end
         end
         checks++;
         if (dv_q.size() != 0) begin
            errors++;
            $display("FAIL glitch_extra_dv case %0d got %0d pulses exp 0", f, dv_q.size());
         end
         checks++;
         if (P_DATA !== e.pdata || Par_err !== e.perr || Stp_err !== e.serr) begin
            errors++;
            $display("FAIL glitch_outputs case %0d got %h/%b/%b exp %h/%b/%b",
                     f, P_DATA, Par_err, Stp_err, e.pdata, e.perr, e.serr);
         end
         dv_q.delete();
      end
   endtask

   // 0x11 and 0x22 with no idle gap, then reset during a third frame's data
   // bits, then a 0x5A odd-parity frame to show reception resumes.
   task automatic test_back_to_back_reset();
      exp_t e;
      dv_t  d;
      int   t;
      for (int f = 0; f < 2; f++) begin
         if (f == 0) begin
            send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 6'd8, -1, 1'b0, t);
            send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 6'd8, -1, 1'b1, t);
         end else begin
            @(negedge clk);
            RX_IN = 1'b0;
            repeat (8) @(negedge clk);
            RX_IN = 1'b1;
            repeat (20) @(negedge clk);
            #2 RST = 1'b0;
            #1;
            checks++;
            if (P_DATA !== 8'h00 || Data_Valid !== 1'b0 || Par_err !== 1'b0 || Stp_err !== 1'b0) begin
               errors++;
               $display("FAIL midframe_reset got %h/%b/%b/%b exp 00/0/0/0",
                        P_DATA, Data_Valid, Par_err, Stp_err);
            end
            model_pdata = 8'h00;
            model_perr  = 1'b0;
            model_serr  = 1'b0;
            @(negedge clk);
            RST = 1'b1;
            repeat (100) @(negedge clk);
            checks++;
            if (dv_q.size() != 0) begin
               errors++;
               $display("FAIL midframe_reset_dv got %0d pulses exp 0", dv_q.size());
            end
            dv_q.delete();
            send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 6'd8, -1, 1'b0, t);
         end
         repeat (4) @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.valid) begin
               checks++;
               if (dv_q.size() == 0) begin
                  errors++;
                  $display("FAIL b2b_dv_missing got none exp cycle %0d", e.cyc);
               end else begin
                  d = dv_q.pop_front();
                  if (d.cyc !== e.cyc) begin
                     errors++;
                     $display("FAIL b2b_dv_cycle got %0d exp %0d", d.cyc, e.cyc);
                  end
                  checks++;
                  if (d.data !== e.pdata) begin
                     errors++;
                     $display("FAIL b2b_dv_data got %h exp %h", d.data, e.pdata);
                  end
               end
            end
         end
         checks++;
         if (dv_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_extra_dv part %0d got %0d pulses exp 0", f, dv_q.size());
         end
         checks++;
         if (P_DATA !== e.pdata || Par_err !== e.perr || Stp_err !== e.serr) begin
            errors++;
            $display("FAIL b2b_outputs part %0d got %h/%b/%b exp %h/%b/%b",
                     f, P_DATA, Par_err, Stp_err, e.pdata, e.perr, e.serr);
         end
         dv_q.delete();
      end
   endtask

   initial begin
      RST         = 1'b1;
      RX_IN       = 1'b1;
      Prescale    = 6'd8;
      PAR_EN      = 1'b0;
      PAR_TYP     = 1'b0;
      model_pdata = 8'h00;
      model_perr  = 1'b0;
      model_serr  = 1'b0;
      test_reset();
      test_parity();
      test_no_parity();
      test_stop_err();
      test_glitch_majority();
      test_back_to_back_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
